// File: rtl/pipeline_pkg.sv
// Shared widths, helpers and entry layout for the pipeline scoreboard.
// Entry state is tracked per stage from EXE (index 0) through WB.
package pipeline_pkg;

    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_NUM_SRC    = 3;

    // Forwarding-select width for a given number of tracked stages.
    function automatic int sel_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Layout of one tracked entry at the default widths. The scoreboard keeps
    // the same fields per stage; src and src_used only matter in stage 0.
    typedef struct packed {
        logic                                          valid;
        logic                                          wb_en;
        logic                                          mem_r_en;
        logic [DEF_REG_ADDR_W-1:0]                     dest;
        logic [DEF_NUM_SRC-1:0][DEF_REG_ADDR_W-1:0]    src;
        logic [DEF_NUM_SRC-1:0]                        src_used;
    } sb_entry_t;

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// ID-stage request and scoreboard response bundle for pipeline_scoreboard.
// The master side is the pipeline control; the slave side is the scoreboard.
interface pipeline_scoreboard_if
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DEPTH      = 3
);
    localparam int SEL_W = sel_width(DEPTH);

    logic                            forwarding_en;
    logic                            freeze;
    logic                            flush;
    logic                            id_valid;
    logic                            id_wb_en;
    logic                            id_mem_r_en;
    logic [REG_ADDR_W-1:0]           id_dest;
    logic [NUM_SRC*REG_ADDR_W-1:0]   id_src;
    logic [NUM_SRC-1:0]              id_src_used;
    logic                            hazard;
    logic [NUM_SRC*SEL_W-1:0]        fwd_sel;
    logic [DEPTH-1:0]                stage_valid;

    modport master (
        output forwarding_en, freeze, flush, id_valid, id_wb_en, id_mem_r_en,
               id_dest, id_src, id_src_used,
        input  hazard, fwd_sel, stage_valid
    );

    modport slave (
        input  forwarding_en, freeze, flush, id_valid, id_wb_en, id_mem_r_en,
               id_dest, id_src, id_src_used,
        output hazard, fwd_sel, stage_valid
    );

endinterface

// File: rtl/sb_match.sv
// Compares one source register index against every tracked stage.
// Purely combinational; produces any-producer and load-producer match vectors.
module sb_match #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3
) (
    input  logic [REG_ADDR_W-1:0]             src,
    input  logic                              src_used,
    input  logic [DEPTH-1:0]                  valid,
    input  logic [DEPTH-1:0]                  wb_en,
    input  logic [DEPTH-1:0]                  mem_r_en,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0]  dest,
    output logic [DEPTH-1:0]                  match,
    output logic [DEPTH-1:0]                  load_match
);

    // Per-stage producer match; register 0 gets no special treatment
    always_comb begin
        match      = {DEPTH{1'b0}};
        load_match = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match[i]      = valid[i] & wb_en[i] & src_used & (dest[i] == src);
            load_match[i] = match[i] & mem_r_en[i];
        end
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// In-flight destination tracker for the core pipeline: ID-stage stall and
// EXE-stage forwarding selects, with configurable depth and load latency.
module pipeline_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_scoreboard_if.slave  sb
);

    localparam int SEL_W = sel_width(DEPTH);

    // WB writes the register file before ID reads, so the last stage never stalls.
    localparam logic [DEPTH-1:0] STALL_MASK = {1'b0, {(DEPTH-1){1'b1}}};
    localparam logic [DEPTH-1:0] LOAD_MASK  = DEPTH'((64'd1 << LOAD_LAT) - 64'd1);
    localparam logic [DEPTH-1:0] LOAD_BLOCK = DEPTH'((64'd1 << (LOAD_LAT + 1)) - 64'd1);
    localparam logic [DEPTH-1:0] FWD_STAGES = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [DEPTH-1:0]                   valid_r;
    logic [DEPTH-1:0]                   wb_en_r;
    logic [DEPTH-1:0]                   mem_r_en_r;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]   dest_r;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_r;
    logic [NUM_SRC-1:0]                 src_used_r;

    logic [DEPTH-1:0]          hz_match_s  [NUM_SRC];
    logic [DEPTH-1:0]          hz_load_s   [NUM_SRC];
    logic [DEPTH-1:0]          fw_match_s  [NUM_SRC];
    logic [DEPTH-1:0]          fw_load_s   [NUM_SRC];
    logic [DEPTH-1:0]          fwd_cand_s  [NUM_SRC];
    logic                      hazard_s;
    logic                      accept_s;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_s;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        sb_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH)
        ) u_hz_match (
            .src        (sb.id_src[s*REG_ADDR_W +: REG_ADDR_W]),
            .src_used   (sb.id_src_used[s]),
            .valid      (valid_r),
            .wb_en      (wb_en_r),
            .mem_r_en   (mem_r_en_r),
            .dest       (dest_r),
            .match      (hz_match_s[s]),
            .load_match (hz_load_s[s])
        );

        sb_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH)
        ) u_fwd_match (
            .src        (src_r[s]),
            .src_used   (src_used_r[s] & valid_r[0]),
            .valid      (valid_r),
            .wb_en      (wb_en_r),
            .mem_r_en   (mem_r_en_r),
            .dest       (dest_r),
            .match      (fw_match_s[s]),
            .load_match (fw_load_s[s])
        );

        // A load is not forwardable until it has spent LOAD_LAT stages past MEM entry.
        assign fwd_cand_s[s] = fw_match_s[s] & FWD_STAGES & ~(fw_load_s[s] & LOAD_BLOCK);
    end

    // ID-stage stall: any producer before WB without forwarding, only young loads with it
    always_comb begin
        hazard_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sb.forwarding_en) begin
                hazard_s = hazard_s | (|(hz_load_s[s] & LOAD_MASK));
            end else begin
                hazard_s = hazard_s | (|(hz_match_s[s] & STALL_MASK));
            end
        end
        hazard_s = hazard_s & sb.id_valid;
    end

    // EXE forwarding select: the lowest matching stage is the youngest producer
    always_comb begin
        fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        if (sb.forwarding_en) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    fwd_sel_s[s*SEL_W +: SEL_W] = fwd_cand_s[s][k] ? SEL_W'(k)
                                                                   : fwd_sel_s[s*SEL_W +: SEL_W];
                end
            end
        end else begin
            fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        end
    end

    assign accept_s = sb.id_valid & ~hazard_s & ~sb.flush;

    // Entry shift register; a frozen pipeline holds every stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r    <= {DEPTH{1'b0}};
            wb_en_r    <= {DEPTH{1'b0}};
            mem_r_en_r <= {DEPTH{1'b0}};
            dest_r     <= {(DEPTH*REG_ADDR_W){1'b0}};
            src_r      <= {(NUM_SRC*REG_ADDR_W){1'b0}};
            src_used_r <= {NUM_SRC{1'b0}};
        end else if (!sb.freeze) begin
            valid_r    <= {valid_r[DEPTH-2:0], accept_s};
            wb_en_r    <= {wb_en_r[DEPTH-2:0], accept_s & sb.id_wb_en};
            mem_r_en_r <= {mem_r_en_r[DEPTH-2:0], accept_s & sb.id_mem_r_en};
            dest_r     <= {dest_r[DEPTH-2:0],
                           accept_s ? sb.id_dest : {REG_ADDR_W{1'b0}}};
            src_r      <= accept_s ? sb.id_src : {(NUM_SRC*REG_ADDR_W){1'b0}};
            src_used_r <= accept_s ? sb.id_src_used : {NUM_SRC{1'b0}};
        end
    end

    assign sb.hazard      = hazard_s;
    assign sb.fwd_sel     = fwd_sel_s;
    assign sb.stage_valid = valid_r;

endmodule
